// File: rtl/zx_vram_pkg.sv
// zx_vram_pkg: shared constants, arbiter state encoding and write-queue entry layout
package zx_vram_pkg;

  localparam int ZX_SCREEN_BYTES = 6912;
  localparam logic [12:0] ZX_ATTR_OFFSET = 13'h1800;

  typedef enum logic [1:0] {IDLE, VID_RD, VID_ACK, CPU_WR} arb_state_t;

  typedef struct packed {
    logic [12:0] offset;
    logic [7:0]  data;
  } fifo_entry_t;

endpackage

// File: rtl/zx_wr_fifo.sv
// zx_wr_fifo: snooped-write queue with push/pop/full/empty/level and a newest-entry data overwrite port
module zx_wr_fifo
  import zx_vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  fifo_entry_t              push_data,
  input  logic                     pop,
  input  logic                     ovr_req,
  input  logic [12:0]              ovr_offset,
  input  logic [7:0]               ovr_data,
  output logic                     ovr_hit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output fifo_entry_t              head
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [12:0] newest_offset;
  logic push_ok, pop_ok;

  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head = mem[rp];
  assign newest_offset = mem[wp - AW'(1)].offset;
  // the newest entry may only absorb new data while it is not leaving the queue this cycle
  assign ovr_hit = ovr_req & ~empty & (newest_offset == ovr_offset) & ~(pop_ok & (level == (AW+1)'(1)));

  // Pointer and occupancy bookkeeping; reset flushes the queue
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok) rp <= rp + AW'(1);
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

  // Entry storage: new writes land at the tail, coalesced writes update the newest entry
  always_ff @(posedge CLK)
    if (push_ok) mem[wp] <= push_data;
    else if (ovr_hit) mem[wp - AW'(1)].data <= ovr_data;

endmodule

// File: rtl/zx_vram_arbiter.sv
// zx_vram_arbiter: shares ZX screen RAM between video fetch and snooped Z80 writes (option: ZX_WR_COALESCE_EN)
module zx_vram_arbiter
  import zx_vram_pkg::*;
#(
  parameter logic [15:0] SCREEN_BASE  = 16'h4000,
  parameter int          SCREEN_BYTES = ZX_SCREEN_BYTES,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        z80_clk,
  input  logic        MRQ,
  input  logic        WR,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        wr_drop,
  output logic [2:0]  fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [2:0] zclk_s, mrq_s, wr_s;
  logic [15:0] a_s0, a_s1, diff;
  logic [7:0] d_s0, d_s1;
  logic armed, in_win, capture, cap_hit;
  logic ovr_req, ovr_hit, push, pop, full, empty;
  logic go_starve, go_vid, go_wr;
  logic [LW-1:0] level;
  logic [SW-1:0] starve_cnt;
  fifo_entry_t head;
  arb_state_t state;

  // Bring the asynchronous Z80 bus into the CLK domain; strobes idle high, z80_clk idles low
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      zclk_s <= 3'b000;
      mrq_s <= 3'b111;
      wr_s <= 3'b111;
      a_s0 <= '0;
      a_s1 <= '0;
      d_s0 <= '0;
      d_s1 <= '0;
    end else begin
      zclk_s <= {zclk_s[1:0], z80_clk};
      mrq_s <= {mrq_s[1:0], MRQ};
      wr_s <= {wr_s[1:0], WR};
      a_s0 <= A;
      a_s1 <= a_s0;
      d_s0 <= D;
      d_s1 <= d_s0;
    end

  assign diff = a_s1 - SCREEN_BASE;
  assign in_win = (a_s1 >= SCREEN_BASE) && ({16'd0, diff} < 32'(SCREEN_BYTES));
  assign capture = zclk_s[1] & ~zclk_s[2] & armed & ~mrq_s[2] & ~wr_s[2];
  assign cap_hit = capture & in_win;

  // One capture per bus write: disarm on capture, re-arm once /WR is seen high again
  always_ff @(posedge CLK or negedge RST)
    if (!RST) armed <= 1'b1;
    else if (capture) armed <= 1'b0;
    else if (wr_s[2]) armed <= 1'b1;

`ifdef ZX_WR_COALESCE_EN
  assign ovr_req = cap_hit;
`else
  assign ovr_req = 1'b0;
`endif

  assign push = cap_hit & ~ovr_hit;
  assign go_starve = ~empty & (starve_cnt == SW'(STARVE_LIMIT));
  assign go_vid = vid_req & ~go_starve;
  assign go_wr = ~empty & ~go_vid;
  // the head leaves the queue as the write slot is granted, so its data is already latched
  assign pop = (state == IDLE) & go_wr;
  assign fifo_level = 3'(level);

  zx_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .push(push),
    .push_data({diff[12:0], d_s1}),
    .pop(pop),
    .ovr_req(ovr_req),
    .ovr_offset(diff[12:0]),
    .ovr_data(d_s1),
    .ovr_hit(ovr_hit),
    .full(full),
    .empty(empty),
    .level(level),
    .head(head)
  );

  // Flag a snooped write lost to a full queue
  always_ff @(posedge CLK or negedge RST)
    if (!RST) wr_drop <= 1'b0;
    else wr_drop <= push & full & ~pop;

  // RAM port scheduler: video reads by default, a forced write slot after STARVE_LIMIT reads
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      vid_ack <= 1'b0;
      vid_data <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      starve_cnt <= '0;
    end else begin
      vid_ack <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE:
          if (go_vid) begin
            state <= VID_RD;
            mem_re <= 1'b1;
            mem_addr <= vid_addr;
          end else if (go_wr) begin
            state <= CPU_WR;
            mem_we <= 1'b1;
            mem_addr <= head.offset;
            mem_wdata <= head.data;
          end
        VID_RD: state <= VID_ACK;
        VID_ACK: begin
          vid_data <= mem_rdata;
          vid_ack <= 1'b1;
          state <= IDLE;
        end
        CPU_WR: state <= IDLE;
      endcase
      if (empty || state == CPU_WR) starve_cnt <= '0;
      else if (state == VID_RD && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// tb_zx_vram_arbiter: directed vectors for the ZX screen RAM arbiter
module tb_zx_vram_arbiter;

  logic CLK = 1'b0, RST = 1'b0, z80_clk = 1'b0, MRQ = 1'b1, WR = 1'b1;
  logic [15:0] A = '0;
  logic [7:0] D = '0;
  logic vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic [7:0] mem_rdata = '0;
  logic vid_ack, mem_we, mem_re, wr_drop;
  logic [7:0] vid_data, mem_wdata;
  logic [12:0] mem_addr;
  logic [2:0] fifo_level;

  int n_checks = 0, n_fail = 0;
  int n_we = 0, n_drop = 0, n_ack = 0, n_viol = 0;
  int re_cnt, ack_cnt, bad_data, snap, max_lvl;
  bit done, found;
  logic [12:0] we_addr;
  logic [7:0] we_data;
  logic [15:0] wa;

  zx_vram_arbiter dut (
    .CLK(CLK), .RST(RST), .z80_clk(z80_clk), .MRQ(MRQ), .WR(WR), .A(A), .D(D),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .wr_drop(wr_drop), .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ram_byte(input logic [12:0] a);
    return a[7:0] ^ a[12:5];
  endfunction

  always @(posedge CLK) if (mem_re) mem_rdata <= ram_byte(mem_addr);

  always @(negedge CLK) begin
    if (mem_we) n_we++;
    if (wr_drop) n_drop++;
    if (vid_ack) n_ack++;
    if (mem_we && mem_re) n_viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic z80_wr(input logic [15:0] a, input logic [7:0] d);
    A = a; D = d; MRQ = 1'b0; WR = 1'b0; z80_clk = 1'b0;
    tick(1);
    z80_clk = 1'b1;
    tick(1);
    MRQ = 1'b1; WR = 1'b1; z80_clk = 1'b0;
    tick(2);
  endtask

  function automatic logic [63:0] outs();
    return {vid_ack, vid_data, mem_addr, mem_wdata, mem_we, mem_re, wr_drop, fifo_level};
  endfunction

  initial begin
    tick(3);
    check("reset_outputs", outs(), 0);
    RST = 1'b1;
    tick(2);

    z80_wr(16'h4000, 8'hAA);
    check("wr1_queued", fifo_level, 1);
    check("wr1_not_yet", mem_we, 0);
    tick(1);
    check("wr1_we", mem_we, 1);
    check("wr1_addr", mem_addr, 13'h0000);
    check("wr1_data", mem_wdata, 8'hAA);
    check("wr1_level", fifo_level, 0);
    tick(2);

    snap = n_we;
    re_cnt = n_drop;
    z80_wr(16'h3FFF, 8'h01);
    z80_wr(16'h5B00, 8'h02);
    tick(4);
    check("win_level", fifo_level, 0);
    check("win_no_we", n_we - snap, 0);
    check("win_no_drop", n_drop - re_cnt, 0);

    z80_wr(16'h5AFF, 8'h3C);
    tick(1);
    check("last_byte_we", mem_we, 1);
    check("last_byte_addr", mem_addr, 13'h1AFF);
    check("last_byte_data", mem_wdata, 8'h3C);
    tick(2);

    vid_addr = 13'h0123;
    vid_req = 1'b1;
    tick(1);
    check("rd_re", mem_re, 1);
    check("rd_addr", mem_addr, 13'h0123);
    tick(1);
    check("rd_ack_early", vid_ack, 0);
    tick(1);
    check("rd_ack", vid_ack, 1);
    check("rd_data", vid_data, 8'h2A);
    vid_req = 1'b0;
    tick(1);
    check("rd_ack_pulse", vid_ack, 0);
    tick(3);

    vid_addr = 13'h1800;
    vid_req = 1'b1;
    re_cnt = 0; ack_cnt = 0; bad_data = 0; done = 1'b0;
    fork
      z80_wr(16'h4100, 8'h55);
      begin
        for (int i = 0; i < 120 && !done; i++) begin
          tick(1);
          if (mem_re && fifo_level != 0) re_cnt++;
          if (re_cnt > 0 && vid_ack) begin
            ack_cnt++;
            if (vid_data !== 8'hC0) bad_data++;
          end
          if (mem_we) begin
            done = 1'b1;
            we_addr = mem_addr;
            we_data = mem_wdata;
          end
        end
      end
    join
    check("starve_forced_wr", done, 1);
    check("starve_reads", re_cnt, 8);
    check("starve_acks", ack_cnt, 8);
    check("starve_vid_data", bad_data, 0);
    check("starve_wr_addr", we_addr, 13'h0100);
    check("starve_wr_data", we_data, 8'h55);
    tick(2);
    check("reads_resume", mem_re, 1);
    snap = n_ack;
    tick(9);
    check("b2b_acks", n_ack - snap, 3);
    vid_req = 1'b0;
    tick(6);

    snap = n_drop;
    re_cnt = n_we;
    max_lvl = 0;
    vid_req = 1'b1;
    fork
      for (int i = 0; i < 5; i++) begin
        wa = 16'h4000 + 16'(i);
        z80_wr(wa, 8'(8'h10 + i));
      end
      for (int i = 0; i < 21; i++) begin
        tick(1);
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
    join
    check("full_level", fifo_level, 4);
    check("full_max_level", max_lvl, 4);
    check("full_one_drop", n_drop - snap, 1);
    vid_req = 1'b0;
    tick(30);
    check("full_drained", fifo_level, 0);
    check("full_retired", n_we - re_cnt, 4);

`ifdef ZX_WR_COALESCE_EN
    vid_req = 1'b1;
    z80_wr(16'h5800, 8'h11);
    z80_wr(16'h5800, 8'h22);
    check("coal_level", fifo_level, 1);
    vid_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1);
      if (mem_we) begin
        done = 1'b1;
        check("coal_addr", mem_addr, 13'h1800);
        check("coal_data", mem_wdata, 8'h22);
      end
    end
    check("coal_retired", done, 1);
    tick(4);
`endif

    vid_addr = 13'h0040;
    vid_req = 1'b1;
    z80_wr(16'h4001, 8'h77);
    check("rst_pre_level", fifo_level, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_re) found = 1'b1;
      else tick(1);
    end
    check("rst_in_vid_rd", found, 1);
    snap = n_ack;
    re_cnt = n_we;
    RST = 1'b0;
    #1;
    check("rst_immediate", outs(), 0);
    tick(3);
    check("rst_held", outs(), 0);
    check("rst_no_ack", n_ack - snap, 0);
    vid_req = 1'b0;
    RST = 1'b1;
    tick(4);
    check("rst_after_level", fifo_level, 0);
    check("rst_after_no_ack", n_ack - snap, 0);
    check("rst_flushed", n_we - re_cnt, 0);

    check("we_re_exclusive", n_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
